// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle 16-bit CPU: opcodes, control FSM states and
// datapath mux/ALU select codes. Used by the controller, the datapath and the bench.
package cpu_pkg;

   localparam int OPC_W = 4;
   localparam int CNT_W = 16;

   localparam logic [OPC_W-1:0] OPC_ADD  = 4'h0;
   localparam logic [OPC_W-1:0] OPC_SUB  = 4'h1;
   localparam logic [OPC_W-1:0] OPC_AND  = 4'h2;
   localparam logic [OPC_W-1:0] OPC_OR   = 4'h3;
   localparam logic [OPC_W-1:0] OPC_ADDI = 4'h4;
   localparam logic [OPC_W-1:0] OPC_LW   = 4'h5;
   localparam logic [OPC_W-1:0] OPC_SW   = 4'h6;
   localparam logic [OPC_W-1:0] OPC_BEQ  = 4'h7;
   localparam logic [OPC_W-1:0] OPC_JMP  = 4'h8;
   localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

   localparam logic [1:0] SRC_B   = 2'd0;
   localparam logic [1:0] SRC_TWO = 2'd1;
   localparam logic [1:0] SRC_IMM = 2'd2;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/ctrl_opc_decode.sv
// Combinational opcode classifier for the control FSM: exactly one class flag is
// high for any opcode value, with codes 9-E falling into is_illegal.
module ctrl_opc_decode
   import cpu_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic             is_rtype,
   output logic             is_addi,
   output logic             is_lw,
   output logic             is_sw,
   output logic             is_beq,
   output logic             is_jmp,
   output logic             is_halt,
   output logic             is_illegal
);

   always_comb begin
      is_rtype   = 1'b0;
      is_addi    = 1'b0;
      is_lw      = 1'b0;
      is_sw      = 1'b0;
      is_beq     = 1'b0;
      is_jmp     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      unique case (opcode)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: is_rtype = 1'b1;
         OPC_ADDI: is_addi = 1'b1;
         OPC_LW:   is_lw   = 1'b1;
         OPC_SW:   is_sw   = 1'b1;
         OPC_BEQ:  is_beq  = 1'b1;
         OPC_JMP:  is_jmp  = 1'b1;
         OPC_HALT: is_halt = 1'b1;
         default:  is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU plus the retired-instruction counter.
// Outputs are Moore decodes of state/opcode; only mem_ready and alu_zero gate combinationally.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int OPC_W = cpu_pkg::OPC_W,
   parameter int CNT_W = cpu_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] opcode,
   input  logic             alu_zero,
   input  logic             mem_ready,
   input  logic             cnt_preload,
   input  logic [CNT_W-1:0] cnt_preload_val,
   output logic             pc_en,
   output logic             ir_en,
   output logic             ab_en,
   output logic             aluout_en,
   output logic             mdr_en,
   output logic             rf_we,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             iord,
   output logic [1:0]       alu_src,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic             wb_sel,
   output logic             instr_done,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count,
   output state_t           state_dbg
);

   // Memory handshake: mem_rd/mem_wr act as the request valid, mem_ready as the
   // completion; the request and iord stay stable every cycle until mem_ready is seen.

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_jmp, is_halt, is_illegal;

   ctrl_opc_decode u_dec (
      .opcode     (opcode),
      .is_rtype   (is_rtype),
      .is_addi    (is_addi),
      .is_lw      (is_lw),
      .is_sw      (is_sw),
      .is_beq     (is_beq),
      .is_jmp     (is_jmp),
      .is_halt    (is_halt),
      .is_illegal (is_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_en      = 1'b0;
      ir_en      = 1'b0;
      ab_en      = 1'b0;
      aluout_en  = 1'b0;
      mdr_en     = 1'b0;
      rf_we      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      alu_src    = SRC_B;
      alu_op     = ALU_ADD;
      pc_src     = PC_ALU;
      wb_sel     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      halted     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            // PC+2 is computed on the ALU while the instruction word is read
            mem_rd  = 1'b1;
            alu_src = SRC_TWO;
            ir_en   = mem_ready;
            pc_en   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ab_en = 1'b1;
            if (is_halt) begin
               state_d = S_HALT;
            end else if (is_illegal) begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            aluout_en = 1'b1;
            state_d   = S_FETCH;
            if (is_rtype) begin
               alu_op  = opcode[1:0];
               state_d = S_WB;
            end else if (is_addi || is_lw || is_sw) begin
               alu_src = SRC_IMM;
               state_d = is_addi ? S_WB : S_MEM;
            end else if (is_beq) begin
               alu_op     = ALU_SUB;
               pc_src     = PC_BRANCH;
               pc_en      = alu_zero;
               instr_done = 1'b1;
            end else if (is_jmp) begin
               pc_src     = PC_JUMP;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
         end
         S_MEM: begin
            iord    = 1'b1;
            state_d = S_FETCH;
            if (is_lw) begin
               mem_rd  = 1'b1;
               mdr_en  = mem_ready;
               state_d = mem_ready ? S_WB : S_MEM;
            end else if (is_sw) begin
               mem_wr     = 1'b1;
               instr_done = mem_ready;
               state_d    = mem_ready ? S_FETCH : S_MEM;
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            wb_sel     = is_lw;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_preload) begin
         cnt_d = cnt_preload_val;
      end else if (instr_done) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign instr_count = cnt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequences, an instruction-level model
// that expands each instruction into its expected per-cycle control pattern.
module tb_multicycle_ctrl;
   import cpu_pkg::*;

   typedef struct packed {
      logic [2:0]  st;
      logic        pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we, mem_rd, mem_wr, iord;
      logic [1:0]  alu_src, alu_op, pc_src;
      logic        wb_sel, instr_done, illegal, halted;
      logic [15:0] cnt;
   } obs_t;
   localparam int OBS_W = $bits(obs_t);

   logic        clk, rst_n;
   logic [3:0]  opcode;
   logic        alu_zero, mem_ready, cnt_preload;
   logic [15:0] cnt_preload_val;
   logic        pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we, mem_rd, mem_wr, iord;
   logic [1:0]  alu_src, alu_op, pc_src;
   logic        wb_sel, instr_done, illegal, halted;
   logic [15:0] instr_count;
   state_t      state_dbg;

   logic [OBS_W-1:0] exp_q[$];
   logic [OBS_W-1:0] care_q[$];
   string            tag_q[$];
   logic [15:0]      model_cnt;
   int               n_checks, n_errors, ncyc;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .cnt_preload(cnt_preload), .cnt_preload_val(cnt_preload_val),
      .pc_en(pc_en), .ir_en(ir_en), .ab_en(ab_en), .aluout_en(aluout_en), .mdr_en(mdr_en),
      .rf_we(rf_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .alu_src(alu_src),
      .alu_op(alu_op), .pc_src(pc_src), .wb_sel(wb_sel), .instr_done(instr_done),
      .illegal(illegal), .halted(halted), .instr_count(instr_count), .state_dbg(state_dbg)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: one expected entry per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         obs_t  e, c, a;
         string t;
         e = obs_t'(exp_q.pop_front());
         c = obs_t'(care_q.pop_front());
         t = tag_q.pop_front();
         a = {state_dbg, pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we, mem_rd, mem_wr, iord,
              alu_src, alu_op, pc_src, wb_sel, instr_done, illegal, halted, instr_count};
         chk(t, 64'(a & c), 64'(e & c));
         chk({t, "_rd_wr_exclusive"}, 64'(mem_rd & mem_wr), 64'(0));
      end
   end

   // Fields that only matter in some states are masked elsewhere.
   function automatic obs_t care_for(input state_t s);
      obs_t c;
      c = '1;
      if (s != S_FETCH) begin
         c.alu_src = '0;
         c.alu_op  = '0;
         c.pc_src  = '0;
      end
      if (s != S_FETCH && s != S_MEM) c.iord = 1'b0;
      if (s != S_WB) c.wb_sel = 1'b0;
      return c;
   endfunction

   task automatic step(input obs_t e, input obs_t c, input string tag, input logic rdy,
                       input logic zero, input logic [3:0] opc, input logic pre);
      @(posedge clk);
      #1;
      mem_ready       = rdy;
      alu_zero        = zero;
      opcode          = opc;
      cnt_preload     = pre;
      cnt_preload_val = 16'hFFFF;
      e.cnt = model_cnt;
      exp_q.push_back(OBS_W'(e));
      care_q.push_back(OBS_W'(c));
      tag_q.push_back(tag);
      if (pre) model_cnt = 16'hFFFF;
      else if (e.instr_done) model_cnt = model_cnt + 16'd1;
      ncyc++;
   endtask

   task automatic release_reset();
      mem_ready   = 1'b0;
      cnt_preload = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      model_cnt = 16'd0;
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      #1;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk({tag, "_state"}, 64'(state_dbg), 64'(S_FETCH));
      chk({tag, "_enables"}, 64'({pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we, mem_wr}), 64'(0));
      chk({tag, "_fetch_outs"}, 64'({mem_rd, iord, alu_src, alu_op, pc_src}), 64'(8'b1_0_01_00_00));
      chk({tag, "_halted"}, 64'(halted), 64'(0));
      chk({tag, "_count"}, 64'(instr_count), 64'(0));
      release_reset();
   endtask

   // Expands one instruction into its cycle-by-cycle expectation.
   task automatic run_instr(input logic [3:0] opc, input int fw, input int mw, input logic zero,
                            input logic pre, input logic abort_mem, output int cycles);
      obs_t e, c;
      int   n0;
      logic rtype, addi, lw, sw, beq, jmp, halt_i, ill;
      n0     = ncyc;
      rtype  = (opc <= 4'd3);
      addi   = (opc == 4'd4);
      lw     = (opc == 4'd5);
      sw     = (opc == 4'd6);
      beq    = (opc == 4'd7);
      jmp    = (opc == 4'd8);
      halt_i = (opc == 4'hF);
      ill    = (opc >= 4'd9) && (opc <= 4'hE);
      cycles = 0;
      for (int i = 0; i <= fw; i++) begin
         e = '0; c = care_for(S_FETCH);
         e.st = S_FETCH; e.mem_rd = 1'b1; e.alu_src = SRC_TWO;
         e.ir_en = (i == fw); e.pc_en = (i == fw);
         step(e, c, "fetch", i == fw, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pre && i == 0);
      end
      e = '0; c = care_for(S_DECODE);
      e.st = S_DECODE; e.ab_en = 1'b1; e.illegal = ill;
      step(e, c, "decode", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opc, 1'b0);
      if (ill || halt_i) begin
         cycles = ncyc - n0;
         return;
      end
      e = '0; c = care_for(S_EXEC);
      e.st = S_EXEC; e.aluout_en = 1'b1;
      if (rtype) begin
         c.alu_src = '1; c.alu_op = '1; e.alu_src = SRC_B; e.alu_op = opc[1:0];
      end else if (addi || lw || sw) begin
         c.alu_src = '1; c.alu_op = '1; e.alu_src = SRC_IMM; e.alu_op = ALU_ADD;
      end else if (beq) begin
         c.alu_src = '1; c.alu_op = '1; c.pc_src = '1;
         e.alu_src = SRC_B; e.alu_op = ALU_SUB; e.pc_src = PC_BRANCH;
         e.pc_en = zero; e.instr_done = 1'b1;
      end else begin
         c.pc_src = '1; e.pc_src = PC_JUMP; e.pc_en = 1'b1; e.instr_done = 1'b1;
      end
      step(e, c, "exec", 1'($urandom_range(0, 1)), zero, opc, 1'b0);
      if (beq || jmp) begin
         cycles = ncyc - n0;
         return;
      end
      if (lw || sw) begin
         if (abort_mem) begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            #1;
            chk("abort_pre_mem_wr", 64'(mem_wr), 64'(1));
            rst_n = 1'b0;
            #1;
            chk("abort_mem_wr", 64'(mem_wr), 64'(0));
            chk("abort_done", 64'(instr_done), 64'(0));
            chk("abort_state", 64'(state_dbg), 64'(S_FETCH));
            chk("abort_count", 64'(instr_count), 64'(0));
            release_reset();
            return;
         end
         for (int i = 0; i <= mw; i++) begin
            e = '0; c = care_for(S_MEM);
            e.st = S_MEM; e.iord = 1'b1; e.mem_rd = lw; e.mem_wr = sw;
            e.mdr_en = lw && (i == mw); e.instr_done = sw && (i == mw);
            step(e, c, "mem", i == mw, 1'($urandom_range(0, 1)), opc, 1'b0);
         end
      end
      if (!sw) begin
         e = '0; c = care_for(S_WB);
         e.st = S_WB; e.rf_we = 1'b1; e.wb_sel = lw; e.instr_done = 1'b1;
         step(e, c, "wb", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opc, 1'b0);
      end
      cycles = ncyc - n0;
   endtask

   // Runs one instruction and pins its latency and resulting count to hand values.
   task automatic instr(input string name, input logic [3:0] opc, input int fw, input int mw,
                        input logic zero, input logic pre, input int exp_cyc, input int exp_cnt);
      int cyc;
      run_instr(opc, fw, mw, zero, pre, 1'b0, cyc);
      chk({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      chk({name, "_count"}, 64'(model_cnt), 64'(exp_cnt));
   endtask

   initial begin
      int   cyc;
      obs_t e, c;
      rst_n = 1'b0; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b0;
      cnt_preload = 1'b0; cnt_preload_val = '0;
      n_checks = 0; n_errors = 0; ncyc = 0; model_cnt = '0;
      apply_reset("reset");

      instr("add",       OPC_ADD,  0, 0, 1'b0, 1'b0, 4, 1);
      instr("sub_fwait", OPC_SUB,  1, 0, 1'b0, 1'b0, 5, 2);
      instr("and",       OPC_AND,  0, 0, 1'b0, 1'b0, 4, 3);
      instr("or",        OPC_OR,   0, 0, 1'b0, 1'b0, 4, 4);
      instr("addi",      OPC_ADDI, 0, 0, 1'b0, 1'b0, 4, 5);
      instr("lw_mwait2", OPC_LW,   0, 2, 1'b0, 1'b0, 7, 6);
      instr("lw_fwait2", OPC_LW,   2, 0, 1'b0, 1'b0, 7, 7);
      instr("sw",        OPC_SW,   0, 0, 1'b0, 1'b0, 4, 8);
      instr("sw_mwait1", OPC_SW,   0, 1, 1'b0, 1'b0, 5, 9);
      instr("beq_taken", OPC_BEQ,  0, 0, 1'b1, 1'b0, 3, 10);
      instr("beq_not",   OPC_BEQ,  0, 0, 1'b0, 1'b0, 3, 11);
      instr("jmp",       OPC_JMP,  0, 0, 1'b0, 1'b0, 3, 12);
      instr("ill_a",     4'hA,     0, 0, 1'b0, 1'b0, 2, 12);
      instr("ill_9",     4'h9,     0, 0, 1'b0, 1'b0, 2, 12);
      instr("ill_e",     4'hE,     1, 0, 1'b0, 1'b0, 3, 12);
      instr("wrap_add",  OPC_ADD,  0, 0, 1'b0, 1'b1, 4, 0);
      instr("after_wrap", OPC_JMP, 0, 0, 1'b0, 1'b0, 3, 1);

      run_instr(OPC_SW, 0, 0, 1'b0, 1'b0, 1'b1, cyc);
      instr("post_abort", OPC_ADD, 0, 0, 1'b0, 1'b0, 4, 1);

      instr("halt", OPC_HALT, 0, 0, 1'b0, 1'b0, 2, 1);
      for (int i = 0; i < 20; i++) begin
         e = '0; c = care_for(S_HALT);
         e.st = S_HALT; e.halted = 1'b1;
         step(e, c, "halt_idle", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 1'b0);
      end
      apply_reset("halt_reset");
      instr("after_halt", OPC_ADDI, 0, 0, 1'b0, 1'b0, 4, 1);

      @(negedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
